// File: rtl/id_pipe_pkg.sv
// id_pipe_pkg: shared opcode, funct, alu constants and instruction decode
package id_pipe_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  typedef logic [7:0] aluop_t;
  typedef logic [2:0] alusel_t;
  localparam aluop_t ALU_NOP = 8'h00;
  localparam aluop_t ALU_AND = 8'h24;
  localparam aluop_t ALU_OR  = 8'h25;
  localparam aluop_t ALU_XOR = 8'h26;
  localparam aluop_t ALU_NOR = 8'h27;
  localparam aluop_t ALU_SLL = 8'h7c;
  localparam aluop_t ALU_SRL = 8'h02;
  localparam aluop_t ALU_SRA = 8'h03;
  localparam alusel_t SEL_NOP   = 3'b000;
  localparam alusel_t SEL_LOGIC = 3'b001;
  localparam alusel_t SEL_SHIFT = 3'b010;
  localparam logic EN  = 1'b1;
  localparam logic DIS = 1'b0;
  typedef struct packed {
    aluop_t      aluop;
    alusel_t     alusel;
    logic        re1;
    logic        re2;
    logic [31:0] imm1;
    logic [31:0] imm2;
    logic [4:0]  wd;
    logic        wreg;
    logic        invalid;
  } dec_t;
  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    d = '0;
    d.invalid = 1'b1;
    case (inst[31:26])
      OP_ORI, OP_ANDI, OP_XORI: begin
        d.aluop = inst[31:26] == OP_ORI ? ALU_OR : inst[31:26] == OP_ANDI ? ALU_AND : ALU_XOR;
        d.alusel = SEL_LOGIC;
        d.re1 = EN;
        d.imm2 = {16'h0, inst[15:0]};
        d.wd = inst[20:16];
        d.wreg = EN;
        d.invalid = 1'b0;
      end
      OP_LUI: begin
        d.aluop = ALU_OR;
        d.alusel = SEL_LOGIC;
        d.imm2 = {inst[15:0], 16'h0};
        d.wd = inst[20:16];
        d.wreg = EN;
        d.invalid = 1'b0;
      end
      OP_SPECIAL: begin
        case (inst[5:0])
          FN_OR, FN_AND, FN_XOR, FN_NOR: begin
            d.aluop = {2'b00, inst[5:0]};
            d.alusel = SEL_LOGIC;
            d.re1 = EN;
            d.re2 = EN;
            d.wd = inst[15:11];
            d.wreg = EN;
            d.invalid = 1'b0;
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            d.aluop = inst[5:0] == FN_SLL ? ALU_SLL : inst[5:0] == FN_SRL ? ALU_SRL : ALU_SRA;
            d.alusel = SEL_SHIFT;
            d.re2 = EN;
            d.imm1 = {27'h0, inst[10:6]};
            d.wd = inst[15:11];
            d.wreg = EN;
            d.invalid = 1'b0;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/id_pipe_fwd_mux.sv
// id_fwd_mux: operand select among immediate, zero register, forwarding sources and regfile
module id_fwd_mux #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int FWD_PORTS = 2
) (
  input  logic                        re_i,
  input  logic [REG_AW-1:0]           addr_i,
  input  logic [DATA_W-1:0]           imm_i,
  input  logic [DATA_W-1:0]           rf_data_i,
  input  logic [FWD_PORTS-1:0]        fwd_wreg_i,
  input  logic [FWD_PORTS*REG_AW-1:0] fwd_wd_i,
  input  logic [FWD_PORTS*DATA_W-1:0] fwd_wdata_i,
  output logic [DATA_W-1:0]           data_o
);
  always_comb begin
    data_o = rf_data_i;
    for (int k = FWD_PORTS - 1; k >= 0; k--)
      if (fwd_wreg_i[k] && fwd_wd_i[k*REG_AW +: REG_AW] == addr_i) data_o = fwd_wdata_i[k*DATA_W +: DATA_W];
    if (addr_i == '0) data_o = '0;
    if (!re_i) data_o = imm_i;
  end
endmodule

// File: rtl/id_pipe.sv
// id_pipe: decode stage with operand forwarding, load-use stall and ID/EX register
module id_pipe
  import id_pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int FWD_PORTS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 pc_i,
  input  logic [31:0]                 inst_i,
  input  logic [DATA_W-1:0]           reg1_data_i,
  input  logic [DATA_W-1:0]           reg2_data_i,
  output logic [REG_AW-1:0]           reg1_addr_o,
  output logic [REG_AW-1:0]           reg2_addr_o,
  input  logic [FWD_PORTS-1:0]        fwd_wreg_i,
  input  logic [FWD_PORTS*REG_AW-1:0] fwd_wd_i,
  input  logic [FWD_PORTS*DATA_W-1:0] fwd_wdata_i,
  input  logic                        ex_is_load_i,
  input  logic                        stall_i,
  input  logic                        flush_i,
  output logic                        stallreq_o,
  output aluop_t                      ex_aluop_o,
  output alusel_t                     ex_alusel_o,
  output logic [DATA_W-1:0]           ex_reg1_o,
  output logic [DATA_W-1:0]           ex_reg2_o,
  output logic [REG_AW-1:0]           ex_wd_o,
  output logic                        ex_wreg_o,
  output logic [31:0]                 ex_pc_o,
  output logic                        ex_invalid_o
);
  dec_t dec;
  logic [DATA_W-1:0] op1, op2;
  logic [REG_AW-1:0] ex_wd0;
  logic hold, bub;
  aluop_t aluop_d, aluop_q;
  alusel_t alusel_d, alusel_q;
  logic [DATA_W-1:0] reg1_d, reg1_q, reg2_d, reg2_q;
  logic [REG_AW-1:0] wd_d, wd_q;
  logic wreg_d, wreg_q, invalid_d, invalid_q;
  logic [31:0] pc_d, pc_q;
  assign dec = decode(inst_i);
  assign reg1_addr_o = REG_AW'(inst_i[25:21]);
  assign reg2_addr_o = REG_AW'(inst_i[20:16]);
  assign ex_wd0 = fwd_wd_i[REG_AW-1:0];
  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_PORTS(FWD_PORTS)) u_mux1 (
    .re_i(dec.re1), .addr_i(reg1_addr_o), .imm_i(DATA_W'(dec.imm1)), .rf_data_i(reg1_data_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i), .data_o(op1)
  );
  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_PORTS(FWD_PORTS)) u_mux2 (
    .re_i(dec.re2), .addr_i(reg2_addr_o), .imm_i(DATA_W'(dec.imm2)), .rf_data_i(reg2_data_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i), .data_o(op2)
  );
  assign stallreq_o = !rst && ex_is_load_i && fwd_wreg_i[0] && ex_wd0 != '0 &&
    ((dec.re1 && ex_wd0 == reg1_addr_o) || (dec.re2 && ex_wd0 == reg2_addr_o));
  always_comb begin
    hold = stall_i && !flush_i;
    bub = flush_i || stallreq_o || dec.invalid;
    aluop_d = hold ? aluop_q : bub ? ALU_NOP : dec.aluop;
    alusel_d = hold ? alusel_q : bub ? SEL_NOP : dec.alusel;
    reg1_d = hold ? reg1_q : bub ? '0 : op1;
    reg2_d = hold ? reg2_q : bub ? '0 : op2;
    wd_d = hold ? wd_q : bub ? '0 : REG_AW'(dec.wd);
    wreg_d = hold ? wreg_q : bub ? 1'b0 : dec.wreg;
    pc_d = hold ? pc_q : bub ? '0 : pc_i;
    invalid_d = hold ? invalid_q : !flush_i && !stallreq_o && dec.invalid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      aluop_q <= ALU_NOP;
      alusel_q <= SEL_NOP;
      reg1_q <= '0;
      reg2_q <= '0;
      wd_q <= '0;
      wreg_q <= 1'b0;
      pc_q <= '0;
      invalid_q <= 1'b0;
    end else begin
      aluop_q <= aluop_d;
      alusel_q <= alusel_d;
      reg1_q <= reg1_d;
      reg2_q <= reg2_d;
      wd_q <= wd_d;
      wreg_q <= wreg_d;
      pc_q <= pc_d;
      invalid_q <= invalid_d;
    end
  end
  assign ex_aluop_o = aluop_q;
  assign ex_alusel_o = alusel_q;
  assign ex_reg1_o = reg1_q;
  assign ex_reg2_o = reg2_q;
  assign ex_wd_o = wd_q;
  assign ex_wreg_o = wreg_q;
  assign ex_pc_o = pc_q;
  assign ex_invalid_o = invalid_q;
endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: directed and randomized checks of id_pipe against a behavioural model
module tb_id_pipe;
  localparam int DW = 32, AW = 5, FP = 2;
  logic clk = 0, rst = 1;
  logic [31:0] pc_i = 0, inst_i = 0;
  logic [DW-1:0] reg1_data_i = 0, reg2_data_i = 0;
  logic [AW-1:0] reg1_addr_o, reg2_addr_o;
  logic [FP-1:0] fwd_wreg_i = 0;
  logic [FP*AW-1:0] fwd_wd_i = 0;
  logic [FP*DW-1:0] fwd_wdata_i = 0;
  logic ex_is_load_i = 0, stall_i = 0, flush_i = 0, stallreq_o;
  logic [7:0] ex_aluop_o;
  logic [2:0] ex_alusel_o;
  logic [DW-1:0] ex_reg1_o, ex_reg2_o;
  logic [AW-1:0] ex_wd_o;
  logic ex_wreg_o, ex_invalid_o;
  logic [31:0] ex_pc_o;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  logic [7:0] e_aluop = 0;
  logic [2:0] e_alusel = 0;
  logic [DW-1:0] e_reg1 = 0, e_reg2 = 0;
  logic [AW-1:0] e_wd = 0;
  logic e_wreg = 0, e_inv = 0;
  logic [31:0] e_pc = 0;

  id_pipe #(.DATA_W(DW), .REG_AW(AW), .FWD_PORTS(FP)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .ex_is_load_i(ex_is_load_i), .stall_i(stall_i), .flush_i(flush_i), .stallreq_o(stallreq_o),
    .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o), .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o),
    .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o), .ex_pc_o(ex_pc_o), .ex_invalid_o(ex_invalid_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  task automatic set_fwd(input int k, input logic we, input logic [AW-1:0] wd, input logic [DW-1:0] data);
    fwd_wreg_i[k] = we;
    fwd_wd_i[k*AW +: AW] = wd;
    fwd_wdata_i[k*DW +: DW] = data;
  endtask

  // MIPS semantics: what each supported instruction reads, produces and writes
  function automatic void ref_dec(input logic [31:0] inst, output bit ok, output logic [7:0] op, output logic [2:0] sel,
                                  output bit r1, output bit r2, output logic [31:0] i1, output logic [31:0] i2, output logic [4:0] wd);
    logic [5:0] opc, fn;
    opc = inst[31:26];
    fn = inst[5:0];
    ok = 1; op = 0; sel = 3'b001; r1 = 0; r2 = 0; i1 = 0; i2 = 0; wd = inst[20:16];
    if (opc == 6'h0d) begin op = 8'h25; r1 = 1; i2 = {16'h0, inst[15:0]}; end
    else if (opc == 6'h0c) begin op = 8'h24; r1 = 1; i2 = {16'h0, inst[15:0]}; end
    else if (opc == 6'h0e) begin op = 8'h26; r1 = 1; i2 = {16'h0, inst[15:0]}; end
    else if (opc == 6'h0f) begin op = 8'h25; i2 = {inst[15:0], 16'h0}; end
    else if (opc == 6'h00 && fn inside {6'h24, 6'h25, 6'h26, 6'h27}) begin op = {2'b0, fn}; r1 = 1; r2 = 1; wd = inst[15:11]; end
    else if (opc == 6'h00 && fn inside {6'h00, 6'h02, 6'h03}) begin
      op = fn == 6'h00 ? 8'h7c : fn == 6'h02 ? 8'h02 : 8'h03;
      sel = 3'b010; r2 = 1; i1 = {27'h0, inst[10:6]}; wd = inst[15:11];
    end
    else ok = 0;
  endfunction

  function automatic logic [DW-1:0] opval(input bit rd, input logic [4:0] a, input logic [31:0] imm, input logic [DW-1:0] rf);
    if (!rd) return imm;
    if (a == 0) return 0;
    for (int k = 0; k < FP; k++)
      if (fwd_wreg_i[k] && fwd_wd_i[k*AW +: AW] == a) return fwd_wdata_i[k*DW +: DW];
    return rf;
  endfunction

  function automatic bit m_stall();
    bit ok, r1, r2;
    logic [7:0] op; logic [2:0] sel; logic [31:0] i1, i2; logic [4:0] wd, w0;
    ref_dec(inst_i, ok, op, sel, r1, r2, i1, i2, wd);
    w0 = fwd_wd_i[AW-1:0];
    return !rst && ex_is_load_i && fwd_wreg_i[0] && w0 != 0 && ((r1 && w0 == inst_i[25:21]) || (r2 && w0 == inst_i[20:16]));
  endfunction

  always @(posedge clk) begin
    bit ok, r1, r2;
    logic [7:0] op; logic [2:0] sel; logic [31:0] i1, i2; logic [4:0] wd;
    ref_dec(inst_i, ok, op, sel, r1, r2, i1, i2, wd);
    if (rst || flush_i || (!stall_i && (m_stall() || !ok))) begin
      {e_aluop, e_alusel, e_reg1, e_reg2, e_wd, e_wreg, e_pc} = '0;
      e_inv = !rst && !flush_i && !m_stall() && !ok;
    end else if (!stall_i) begin
      e_aluop = op; e_alusel = sel; e_wd = wd; e_wreg = 1; e_pc = pc_i; e_inv = 0;
      e_reg1 = opval(r1, inst_i[25:21], i1, reg1_data_i);
      e_reg2 = opval(r2, inst_i[20:16], i2, reg2_data_i);
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("aluop", ex_aluop_o, e_aluop);
    chk("alusel", ex_alusel_o, e_alusel);
    chk("reg1", ex_reg1_o, e_reg1);
    chk("reg2", ex_reg2_o, e_reg2);
    chk("wd", ex_wd_o, e_wd);
    chk("wreg", ex_wreg_o, e_wreg);
    chk("pc", ex_pc_o, e_pc);
    chk("invalid", ex_invalid_o, e_inv);
    chk("stallreq", stallreq_o, m_stall());
    chk("raddr1", reg1_addr_o, inst_i[25:21]);
    chk("raddr2", reg2_addr_o, inst_i[20:16]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ex_is_load_i = 1;
    set_fwd(0, 1, 1, 32'h1);
    inst_i = itype(6'h0d, 1, 2, 16'h1);
    #1 chk("stallreq_in_rst", stallreq_o, 0);
    tick();
    tick();
    chk("rst_wreg", ex_wreg_o, 0);
    chk("rst_aluop", ex_aluop_o, 0);
    chk("rst_invalid", ex_invalid_o, 0);
    chk_en = 1;
    rst = 0; ex_is_load_i = 0; set_fwd(0, 0, 0, 0);
    inst_i = itype(6'h0d, 0, 1, 16'h1100); pc_i = 32'h40;
    tick();
    chk("ori_aluop", ex_aluop_o, 8'h25);
    chk("ori_reg1", ex_reg1_o, 0);
    chk("ori_reg2", ex_reg2_o, 32'h1100);
    chk("ori_wd", ex_wd_o, 1);
    chk("ori_wreg", ex_wreg_o, 1);
    inst_i = rtype(1, 2, 3, 0, 6'h25);
    set_fwd(0, 1, 1, 32'hAAAA0000); set_fwd(1, 1, 1, 32'h5555);
    reg1_data_i = 32'h12345678; reg2_data_i = 32'h0F0F;
    tick();
    chk("fwd_prio_reg1", ex_reg1_o, 32'hAAAA0000);
    chk("fwd_prio_reg2", ex_reg2_o, 32'h0F0F);
    inst_i = rtype(0, 0, 3, 0, 6'h25);
    set_fwd(0, 1, 0, 32'hFFFFFFFF); set_fwd(1, 0, 0, 0);
    tick();
    chk("zero_reg1", ex_reg1_o, 0);
    chk("zero_reg2", ex_reg2_o, 0);
    set_fwd(0, 1, 2, 32'h77); ex_is_load_i = 1;
    inst_i = rtype(2, 5, 4, 0, 6'h24);
    #1 chk("loaduse_req", stallreq_o, 1);
    tick();
    chk("loaduse_bub_wreg", ex_wreg_o, 0);
    chk("loaduse_bub_aluop", ex_aluop_o, 0);
    ex_is_load_i = 0; set_fwd(0, 0, 0, 0); reg1_data_i = 32'h1111;
    #1 chk("loaduse_release", stallreq_o, 0);
    tick();
    chk("and_aluop", ex_aluop_o, 8'h24);
    chk("and_wd", ex_wd_o, 4);
    chk("and_reg1", ex_reg1_o, 32'h1111);
    inst_i = 32'hFC000000;
    tick();
    chk("inv_set", ex_invalid_o, 1);
    chk("inv_wreg", ex_wreg_o, 0);
    inst_i = itype(6'h0d, 0, 7, 16'h5); pc_i = 32'h100;
    tick();
    chk("inv_clear", ex_invalid_o, 0);
    stall_i = 1; inst_i = rtype(2, 5, 4, 0, 6'h26); pc_i = 32'h104;
    set_fwd(0, 1, 2, 0); ex_is_load_i = 1;
    #1 chk("stall_req_kept", stallreq_o, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hold_aluop", ex_aluop_o, 8'h25);
      chk("hold_pc", ex_pc_o, 32'h100);
    end
    ex_is_load_i = 0; set_fwd(0, 0, 0, 0); flush_i = 1;
    tick();
    chk("flush_wreg", ex_wreg_o, 0);
    chk("flush_pc", ex_pc_o, 0);
    flush_i = 0; stall_i = 0; inst_i = itype(6'h0f, 0, 9, 16'hBEEF); pc_i = 32'h108;
    tick();
    chk("lui_reg2", ex_reg2_o, 32'hBEEF0000);
    rst = 1; stall_i = 1;
    tick();
    chk("rst_stall_wreg", ex_wreg_o, 0);
    chk("rst_stall_pc", ex_pc_o, 0);
    rst = 0; stall_i = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [5:0] fns [7] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03};
      logic [5:0] ops [4] = '{6'h0c, 6'h0d, 6'h0e, 6'h0f};
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) inst_i = itype(ops[$urandom_range(0, 3)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom));
      else if (r < 9) inst_i = rtype(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom), fns[$urandom_range(0, 6)]);
      else inst_i = $urandom;
      pc_i = $urandom; reg1_data_i = $urandom; reg2_data_i = $urandom;
      for (int k = 0; k < FP; k++) set_fwd(k, 1'($urandom), AW'($urandom_range(0, 3)), $urandom);
      ex_is_load_i = $urandom_range(0, 9) < 3;
      stall_i = $urandom_range(0, 9) == 0;
      flush_i = $urandom_range(0, 19) == 0;
      rst = $urandom_range(0, 49) == 0;
      tick();
    end
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
